// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_STORE,
    ST_DONE
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_FETCH,
    GNT_LOAD,
    GNT_STORE
  } grant_e;

  localparam logic [3:0]  SIZE_WORD = 4'd0;
  localparam logic [3:0]  SIZE_HALF = 4'd2;
  localparam logic [3:0]  SIZE_BYTE = 4'd3;

  localparam logic        TRUE  = 1'b1;
  localparam logic        FALSE = 1'b0;
  localparam logic [31:0] ZERO  = 32'h0;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and memory-controller signals between the arbiter and its neighbours.
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        flush_i;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc_o;
  logic        if_done_o;

  logic        ls_r_req_i;
  logic        ls_w_req_i;
  logic [31:0] ls_addr_i;
  logic [3:0]  ls_size_i;
  logic [31:0] ls_w_data_i;
  logic [31:0] ls_r_data_o;
  logic        ls_done_o;

  logic        mc_inst_req_o;
  logic [31:0] mc_inst_addr_o;
  logic        mc_r_req_o;
  logic        mc_w_req_o;
  logic [31:0] mc_addr_o;
  logic [3:0]  mc_ptr_o;
  logic [31:0] mc_w_data_o;
  logic [31:0] mc_inst_i;
  logic [31:0] mc_inst_pc_i;
  logic        mc_inst_done_i;
  logic [31:0] mc_r_data_i;
  logic        mc_done_i;

  modport master (
    input  if_req_i, if_addr_i, flush_i,
    input  ls_r_req_i, ls_w_req_i, ls_addr_i, ls_size_i, ls_w_data_i,
    input  mc_inst_i, mc_inst_pc_i, mc_inst_done_i, mc_r_data_i, mc_done_i,
    output if_inst_o, if_pc_o, if_done_o, ls_r_data_o, ls_done_o,
    output mc_inst_req_o, mc_inst_addr_o, mc_r_req_o, mc_w_req_o,
    output mc_addr_o, mc_ptr_o, mc_w_data_o
  );

  modport slave (
    output if_req_i, if_addr_i, flush_i,
    output ls_r_req_i, ls_w_req_i, ls_addr_i, ls_size_i, ls_w_data_i,
    output mc_inst_i, mc_inst_pc_i, mc_inst_done_i, mc_r_data_i, mc_done_i,
    input  if_inst_o, if_pc_o, if_done_o, ls_r_data_o, ls_done_o,
    input  mc_inst_req_o, mc_inst_addr_o, mc_r_req_o, mc_w_req_o,
    input  mc_addr_o, mc_ptr_o, mc_w_data_o
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Grant selection: store > load > fetch, with fetch forced once it has waited STARVE_LIM data grants.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter logic [2:0] STARVE_LIM = 3'd4
) (
  input  logic [2:0] starve_cnt,
  input  logic       if_req,
  input  logic       flush,
  input  logic       ls_r_req,
  input  logic       ls_w_req,
  output grant_e     grant
);
  logic fetch_ok;

  always_comb begin
    fetch_ok = if_req && !flush;
    grant    = GNT_NONE;
    if (fetch_ok && starve_cnt == STARVE_LIM) grant = GNT_FETCH;
    else if (ls_w_req)                        grant = GNT_STORE;
    else if (ls_r_req)                        grant = GNT_LOAD;
    else if (fetch_ok)                        grant = GNT_FETCH;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises instruction fetches and loads/stores onto one controller.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus
);
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  arb_state_e state;
  grant_e     grant;
  logic       stale;
  logic [2:0] starve_cnt;

  mem_arb_pick #(.STARVE_LIM(STARVE_LIM)) u_pick (
    .starve_cnt (starve_cnt),
    .if_req     (bus.if_req_i),
    .flush      (bus.flush_i),
    .ls_r_req   (bus.ls_r_req_i),
    .ls_w_req   (bus.ls_w_req_i),
    .grant      (grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= ST_IDLE;
      stale              <= FALSE;
      starve_cnt         <= '0;
      bus.if_done_o      <= FALSE;
      bus.ls_done_o      <= FALSE;
      bus.mc_inst_req_o  <= FALSE;
      bus.mc_r_req_o     <= FALSE;
      bus.mc_w_req_o     <= FALSE;
      bus.mc_inst_addr_o <= ZERO;
      bus.mc_addr_o      <= ZERO;
      bus.mc_w_data_o    <= ZERO;
      bus.mc_ptr_o       <= SIZE_WORD;
      bus.if_inst_o      <= ZERO;
      bus.if_pc_o        <= ZERO;
      bus.ls_r_data_o    <= ZERO;
    end else begin
      bus.if_done_o <= FALSE;
      bus.ls_done_o <= FALSE;
      unique case (state)
        ST_IDLE: begin
          if (!bus.if_req_i) starve_cnt <= '0;
          if (grant == GNT_LOAD || grant == GNT_STORE) begin
            bus.mc_addr_o   <= bus.ls_addr_i;
            bus.mc_ptr_o    <= bus.ls_size_i;
            bus.mc_w_data_o <= bus.ls_w_data_i;
            if (bus.if_req_i && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 3'd1;
          end
          unique case (grant)
            GNT_FETCH: begin
              state              <= ST_FETCH;
              bus.mc_inst_req_o  <= TRUE;
              bus.mc_inst_addr_o <= bus.if_addr_i;
              starve_cnt         <= '0;
            end
            GNT_STORE: begin
              state          <= ST_STORE;
              bus.mc_w_req_o <= TRUE;
            end
            GNT_LOAD: begin
              state          <= ST_LOAD;
              bus.mc_r_req_o <= TRUE;
            end
            default: ;
          endcase
        end
        // A flushed fetch is still in flight at the controller, so wait for its return and drop the result.
        ST_FETCH: begin
          if (bus.mc_inst_done_i) begin
            bus.mc_inst_req_o <= FALSE;
            state             <= ST_DONE;
            if (!(stale || bus.flush_i)) begin
              bus.if_inst_o <= bus.mc_inst_i;
              bus.if_pc_o   <= bus.mc_inst_pc_i;
              bus.if_done_o <= TRUE;
            end
          end else if (bus.flush_i) begin
            stale             <= TRUE;
            bus.mc_inst_req_o <= FALSE;
          end
        end
        ST_LOAD: begin
          if (bus.mc_done_i) begin
            bus.mc_r_req_o  <= FALSE;
            bus.ls_r_data_o <= bus.mc_r_data_i;
            bus.ls_done_o   <= TRUE;
            state           <= ST_DONE;
          end
        end
        ST_STORE: begin
          if (bus.mc_done_i) begin
            bus.mc_w_req_o <= FALSE;
            bus.ls_done_o  <= TRUE;
            state          <= ST_DONE;
          end
        end
        ST_DONE: begin
          stale <= FALSE;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level grant-order model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned SMAX = 4;
  localparam int K_F = 1, K_L = 2, K_S = 3, K_FD = 4, K_LD = 5;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [3:0]  p;
    logic [31:0] d;
    int          cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();
  mem_arbiter #(.STARVE_MAX(SMAX)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0, n_fail = 0, cyc = 0, inst_done_cyc = 0;
  int unsigned lat = 2;
  ev_t glog[$], dlog[$];

  // Memory controller model plus event monitor, both evaluated on the falling edge.
  logic pi = 1'b0, pd = 1'b0;
  int unsigned ci = 0, cd = 0;
  logic [31:0] ia = '0, da = '0;
  initial begin
    bus.mc_done_i = 1'b0; bus.mc_inst_done_i = 1'b0;
    bus.mc_inst_i = '0; bus.mc_inst_pc_i = '0; bus.mc_r_data_i = '0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.mc_done_i = 1'b0;
      bus.mc_inst_done_i = 1'b0;
      if (bus.mc_inst_req_o && !pi) begin
        ci = lat; ia = bus.mc_inst_addr_o;
        glog.push_back('{kind:K_F, a:ia, p:4'h0, d:32'h0, cyc:cyc});
      end else if (ci != 0) begin
        ci--;
        if (ci == 0) begin
          bus.mc_inst_done_i = 1'b1; bus.mc_inst_i = ia ^ 32'h1013;
          bus.mc_inst_pc_i = ia; inst_done_cyc = cyc;
        end
      end
      if ((bus.mc_r_req_o || bus.mc_w_req_o) && !pd) begin
        cd = lat; da = bus.mc_addr_o;
        if (bus.mc_w_req_o) glog.push_back('{kind:K_S, a:da, p:bus.mc_ptr_o, d:bus.mc_w_data_o, cyc:cyc});
        else                glog.push_back('{kind:K_L, a:da, p:bus.mc_ptr_o, d:32'h0, cyc:cyc});
      end else if (cd != 0) begin
        cd--;
        if (cd == 0) begin
          bus.mc_done_i = 1'b1; bus.mc_r_data_i = da ^ 32'hDEAD_BEEF;
        end
      end
      if (bus.if_done_o) dlog.push_back('{kind:K_FD, a:bus.if_pc_o, p:4'h0, d:bus.if_inst_o, cyc:cyc});
      if (bus.ls_done_o) dlog.push_back('{kind:K_LD, a:32'h0, p:4'h0, d:bus.ls_r_data_o, cyc:cyc});
      pi = bus.mc_inst_req_o;
      pd = bus.mc_r_req_o || bus.mc_w_req_o;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input bit fetch_side, input int budget);
    int n = 0;
    while (((fetch_side ? bus.if_done_o : bus.ls_done_o) !== 1'b1) && n < budget) begin
      step();
      n++;
    end
    check(tag, fetch_side ? bus.if_done_o : bus.ls_done_o, 1'b1);
  endtask

  task automatic drive_ls(input ev_t o, input bit en);
    bus.ls_r_req_i  = en && o.kind == K_L;
    bus.ls_w_req_i  = en && o.kind == K_S;
    bus.ls_addr_i   = o.a;
    bus.ls_size_i   = o.p;
    bus.ls_w_data_i = o.d;
  endtask

  initial begin : main
    int unsigned nf, nls, fi, li, starve;
    logic [31:0] fa[$];
    ev_t lsq[$], expg[$];
    logic [31:0] last_load;
    logic [3:0] szt [3];
    int nfd;

    bus.if_req_i = 0; bus.if_addr_i = '0; bus.flush_i = 0;
    bus.ls_r_req_i = 0; bus.ls_w_req_i = 0; bus.ls_addr_i = '0;
    bus.ls_size_i = '0; bus.ls_w_data_i = '0;
    repeat (3) step();

    check("rst_done", {bus.if_done_o, bus.ls_done_o}, 0);
    check("rst_mc_req", {bus.mc_inst_req_o, bus.mc_r_req_o, bus.mc_w_req_o}, 0);
    check("rst_addr", bus.mc_addr_o | bus.mc_inst_addr_o | bus.mc_w_data_o, 0);
    check("rst_ptr", bus.mc_ptr_o, 0);
    check("rst_results", bus.if_inst_o | bus.if_pc_o | bus.ls_r_data_o, 0);
    rst = 1'b1;
    step();

    // Plain fetch
    lat = 2;
    bus.if_req_i = 1; bus.if_addr_i = 32'h1000;
    step();
    check("fetch_req_rise", bus.mc_inst_req_o, 1);
    check("fetch_no_data_req", {bus.mc_r_req_o, bus.mc_w_req_o}, 0);
    check("fetch_inst_addr", bus.mc_inst_addr_o, 32'h1000);
    wait_done("fetch_done", 1, 40);
    check("fetch_inst", bus.if_inst_o, 32'h13);
    check("fetch_pc", bus.if_pc_o, 32'h1000);
    bus.if_req_i = 0;
    step();
    check("fetch_done_one_cycle", bus.if_done_o, 0);

    // Store and fetch in the same cycle: store wins
    bus.ls_w_req_i = 1; bus.ls_addr_i = 32'h20; bus.ls_size_i = SIZE_BYTE; bus.ls_w_data_i = 32'hAB;
    bus.if_req_i = 1; bus.if_addr_i = 32'h2000;
    step();
    check("sf_store_first", {bus.mc_w_req_o, bus.mc_inst_req_o, bus.mc_r_req_o}, 3'b100);
    check("sf_ptr", bus.mc_ptr_o, 3);
    check("sf_addr", bus.mc_addr_o, 32'h20);
    check("sf_wdata", bus.mc_w_data_o, 32'hAB);
    wait_done("sf_store_done", 0, 40);
    bus.ls_w_req_i = 0;
    step();
    check("sf_no_early_fetch", bus.mc_inst_req_o, 0);
    step();
    check("sf_fetch_next", bus.mc_inst_req_o, 1);
    check("sf_fetch_addr", bus.mc_inst_addr_o, 32'h2000);
    wait_done("sf_fetch_done", 1, 40);
    bus.if_req_i = 0;
    step();

    // Store operands held while the store is outstanding
    lat = 5;
    bus.ls_w_req_i = 1; bus.ls_addr_i = 32'h40; bus.ls_size_i = SIZE_WORD; bus.ls_w_data_i = 32'h1234_5678;
    step();
    bus.ls_addr_i = 32'h99; bus.ls_w_data_i = 32'hFFFF_0000; bus.ls_size_i = SIZE_HALF;
    step();
    check("hold_addr", bus.mc_addr_o, 32'h40);
    check("hold_wdata", bus.mc_w_data_o, 32'h1234_5678);
    check("hold_ptr", bus.mc_ptr_o, SIZE_WORD);
    step(); step();
    check("hold_addr_late", bus.mc_addr_o, 32'h40);
    wait_done("hold_done", 0, 40);
    bus.ls_w_req_i = 0;
    step();

    // Simultaneous load and store: store, then load
    lat = 1; glog.delete(); dlog.delete();
    bus.ls_r_req_i = 1; bus.ls_w_req_i = 1; bus.ls_addr_i = 32'h80;
    bus.ls_size_i = SIZE_WORD; bus.ls_w_data_i = 32'h55;
    wait_done("rw_store_done", 0, 40);
    check("rw_store_holds_rdata", bus.ls_r_data_o, 32'h0);
    bus.ls_w_req_i = 0;
    step();
    wait_done("rw_load_done", 0, 40);
    check("rw_load_data", bus.ls_r_data_o, 32'h80 ^ 32'hDEAD_BEEF);
    bus.ls_r_req_i = 0;
    step();
    check("rw_grant_count", glog.size(), 2);
    if (glog.size() == 2) begin
      check("rw_first_store", glog[0].kind, K_S);
      check("rw_then_load", glog[1].kind, K_L);
    end

    // Starvation: held loads yield to the fetch after SMAX grants
    lat = $urandom_range(1, 3); glog.delete();
    bus.if_req_i = 1; bus.if_addr_i = 32'h4000;
    bus.ls_r_req_i = 1; bus.ls_addr_i = 32'h300; bus.ls_size_i = SIZE_WORD;
    wait_done("starve_fetch_done", 1, 150);
    bus.if_req_i = 0; bus.ls_r_req_i = 0;
    step();
    check("starve_grant_count", glog.size(), SMAX + 1);
    for (int i = 0; i < int'(SMAX) + 1 && i < glog.size(); i++)
      check($sformatf("starve_kind%0d", i), glog[i].kind, (i == int'(SMAX)) ? K_F : K_L);

    // Flush during a fetch with a load waiting behind it
    lat = 6; glog.delete(); dlog.delete();
    bus.if_req_i = 1; bus.if_addr_i = 32'h5000;
    step();
    check("flush_fetch_active", bus.mc_inst_req_o, 1);
    bus.ls_r_req_i = 1; bus.ls_addr_i = 32'h600;
    step();
    bus.flush_i = 1; bus.if_req_i = 0;
    step();
    bus.flush_i = 0;
    check("flush_req_drop", bus.mc_inst_req_o, 0);
    check("flush_no_early_load", bus.mc_r_req_o, 0);
    wait_done("flush_load_done", 0, 60);
    check("flush_load_data", bus.ls_r_data_o, 32'h600 ^ 32'hDEAD_BEEF);
    bus.ls_r_req_i = 0;
    step();
    nfd = 0;
    foreach (dlog[i]) if (dlog[i].kind == K_FD) nfd++;
    check("flush_no_if_done", nfd, 0);
    check("flush_grant_count", glog.size(), 2);
    if (glog.size() == 2) check("flush_load_gap", glog[1].cyc - inst_done_cyc, 3);

    // Reset in the middle of a load
    lat = 8; glog.delete(); dlog.delete();
    bus.ls_r_req_i = 1; bus.ls_addr_i = 32'h700;
    step();
    check("rstmid_load_active", bus.mc_r_req_o, 1);
    step(); step();
    rst = 1'b0; bus.ls_r_req_i = 0;
    #1;
    check("rstmid_req", {bus.mc_inst_req_o, bus.mc_r_req_o, bus.mc_w_req_o}, 0);
    check("rstmid_addr", bus.mc_addr_o | bus.mc_w_data_o | bus.mc_inst_addr_o, 0);
    check("rstmid_rdata", bus.ls_r_data_o, 0);
    check("rstmid_ptr", bus.mc_ptr_o, 0);
    step();
    rst = 1'b1;
    repeat (12) step();
    check("rstmid_no_done", dlog.size(), 0);
    check("rstmid_no_regrant", glog.size(), 1);

    // Randomized mix against the transaction-level model
    szt = '{SIZE_WORD, SIZE_HALF, SIZE_BYTE};
    nf = $urandom_range(3, 8);
    nls = $urandom_range(4, 12);
    for (int unsigned i = 0; i < nf; i++) fa.push_back($urandom & 32'hFFFF_FFFC);
    for (int unsigned i = 0; i < nls; i++)
      lsq.push_back('{kind:($urandom_range(0, 1) != 0) ? K_S : K_L, a:$urandom & 32'hFFFF_FFFC,
                      p:szt[$urandom_range(0, 2)], d:$urandom, cyc:0});
    starve = 0; fi = 0; li = 0;
    while (fi < nf || li < nls) begin
      if (fi < nf && (li >= nls || starve == SMAX)) begin
        expg.push_back('{kind:K_F, a:fa[fi], p:4'h0, d:32'h0, cyc:0});
        fi++; starve = 0;
      end else begin
        expg.push_back('{kind:lsq[li].kind, a:lsq[li].a, p:lsq[li].p,
                         d:(lsq[li].kind == K_S) ? lsq[li].d : 32'h0, cyc:0});
        li++;
        starve = (fi < nf) ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
      end
    end

    glog.delete(); dlog.delete();
    fi = 0; li = 0;
    bus.if_req_i = 1; bus.if_addr_i = fa[0];
    drive_ls(lsq[0], 1);
    for (int n = 0; n < 3000 && (fi < nf || li < nls); n++) begin
      lat = $urandom_range(1, 4);
      step();
      if (bus.if_done_o) begin
        fi++;
        bus.if_req_i = fi < nf;
        if (fi < nf) bus.if_addr_i = fa[fi];
      end
      if (bus.ls_done_o) begin
        li++;
        if (li < nls) drive_ls(lsq[li], 1);
        else drive_ls(lsq[0], 0);
      end
    end
    step(); step();
    check("rand_complete", (fi == nf) && (li == nls), 1);
    check("rand_grant_count", glog.size(), expg.size());
    check("rand_done_count", dlog.size(), expg.size());
    last_load = 32'h0;
    for (int i = 0; i < expg.size() && i < glog.size() && i < dlog.size(); i++) begin
      check($sformatf("rand_kind%0d", i), glog[i].kind, expg[i].kind);
      check($sformatf("rand_addr%0d", i), glog[i].a, expg[i].a);
      check($sformatf("rand_ptr%0d", i), glog[i].p, expg[i].p);
      check($sformatf("rand_wdata%0d", i), glog[i].d, expg[i].d);
      if (expg[i].kind == K_F) begin
        check($sformatf("rand_dkind%0d", i), dlog[i].kind, K_FD);
        check($sformatf("rand_pc%0d", i), dlog[i].a, expg[i].a);
        check($sformatf("rand_inst%0d", i), dlog[i].d, expg[i].a ^ 32'h1013);
      end else begin
        if (expg[i].kind == K_L) last_load = expg[i].a ^ 32'hDEAD_BEEF;
        check($sformatf("rand_dkind%0d", i), dlog[i].kind, K_LD);
        check($sformatf("rand_rdata%0d", i), dlog[i].d, last_load);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end
endmodule
